// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Key code table, FSM state encoding and default timing values.
package keypad_pkg;

  localparam int unsigned SCAN_DIV_DEF        = 1200;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 240000;
  localparam int unsigned NROWS               = 4;
  localparam int unsigned NCOLS               = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // Hex code of each key, indexed [row][col].
  localparam logic [3:0] KEYMAP [NROWS][NCOLS] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // Index of the lowest-numbered row reading low (caller guarantees one exists).
  function automatic logic [1:0] first_low(input logic [3:0] r);
    first_low = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!r[i]) first_low = 2'(i);
    end
  endfunction

endpackage

// File: rtl/keypad_scanner_sync.sv
// Two-flop synchronizer for asynchronous inputs; resets to all-ones
// so an idle pulled-up bus reads inactive.
module sync2 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates one active-low column, debounces
// the pressed row and keeps a two-deep history of registered key codes.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = SCAN_DIV_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] s1,
  output logic [3:0] s2,
  output logic       new_key
);

  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEBOUNCE_CYCLES);

  state_t            state, state_n;
  logic [1:0]        col_idx, col_n;
  logic [1:0]        row_q, row_n;
  logic [SCAN_W-1:0] scan_cnt, scan_n;
  logic [DEB_W-1:0]  deb_cnt, deb_n, deb_inc;
  logic [3:0]        s1_n, s2_n;
  logic              new_key_n;
  logic [3:0]        rows_s;
  logic              row_hi;

  sync2 #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rows),
    .q     (rows_s)
  );

  // Level of the captured row in the frozen column.
  assign row_hi  = rows_s[row_q];
  // Debounce counter saturates instead of wrapping.
  assign deb_inc = (deb_cnt >= DEB_MAX) ? deb_cnt : deb_cnt + DEB_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SCAN;
      col_idx  <= 2'd0;
      row_q    <= 2'd0;
      scan_cnt <= '0;
      deb_cnt  <= '0;
      cols     <= 4'b1110;
      s1       <= 4'h0;
      s2       <= 4'h0;
      new_key  <= 1'b0;
    end else begin
      state    <= state_n;
      col_idx  <= col_n;
      row_q    <= row_n;
      scan_cnt <= scan_n;
      deb_cnt  <= deb_n;
      cols     <= ~(4'b0001 << col_n);
      s1       <= s1_n;
      s2       <= s2_n;
      new_key  <= new_key_n;
    end
  end

  always_comb begin
    state_n   = state;
    col_n     = col_idx;
    row_n     = row_q;
    scan_n    = scan_cnt;
    deb_n     = deb_cnt;
    s1_n      = s1;
    s2_n      = s2;
    new_key_n = 1'b0;

    case (state)
      SCAN: begin
        if (scan_cnt >= SCAN_LAST) begin
          scan_n = '0;
          if (rows_s != 4'b1111) begin
            // Freeze this column and lock onto the lowest pressed row.
            row_n   = first_low(rows_s);
            deb_n   = '0;
            state_n = DEBOUNCE;
          end else begin
            col_n = col_idx + 2'd1;
          end
        end else begin
          scan_n = scan_cnt + SCAN_W'(1);
        end
      end

      DEBOUNCE: begin
        if (row_hi) begin
          state_n = SCAN;
          col_n   = col_idx + 2'd1;
          scan_n  = '0;
          deb_n   = '0;
        end else if (deb_cnt >= DEB_LAST) begin
          s2_n      = s1;
          s1_n      = KEYMAP[row_q][col_idx];
          new_key_n = 1'b1;
          deb_n     = '0;
          state_n   = HELD;
        end else begin
          deb_n = deb_inc;
        end
      end

      HELD: begin
        if (row_hi) begin
          deb_n   = '0;
          state_n = RELEASE;
        end
      end

      RELEASE: begin
        if (!row_hi) begin
          deb_n   = '0;
          state_n = HELD;
        end else if (deb_cnt >= DEB_LAST) begin
          state_n = SCAN;
          col_n   = col_idx + 2'd1;
          scan_n  = '0;
          deb_n   = '0;
        end else begin
          deb_n = deb_inc;
        end
      end

      default: begin
        state_n = SCAN;
        scan_n  = '0;
        deb_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed and randomized checks of keypad_scanner against a keypad
// model and a key-history reference.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] s1, s2;
  logic       new_key;

  logic [3:0][3:0] pressed;
  logic [3:0]      km [4][4];

  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  logic prev_nk = 1'b0;
  logic dbl     = 1'b0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .rows    (rows),
    .cols    (cols),
    .s1      (s1),
    .s2      (s2),
    .new_key (new_key)
  );

  always #5 clk = ~clk;

  // Keypad: a row reads low when any pressed key in it sits in a driven column.
  always_comb begin
    rows = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && !cols[c]) rows[r] = 1'b0;
  end

  always @(posedge clk) begin
    prev_nk <= new_key;
    if (new_key === 1'b1) pulses <= pulses + 1;
    if (new_key === 1'b1 && prev_nk === 1'b1) dbl <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int r, input int c);
    pressed[r][c] = 1'b1;
  endtask

  task automatic release_all();
    pressed = '0;
  endtask

  task automatic check_hist(input string tag, input logic [3:0] e1, input logic [3:0] e2,
                            input int epulses);
    check({tag, "_s1"}, 32'(s1), 32'(e1));
    check({tag, "_s2"}, 32'(s2), 32'(e2));
    check({tag, "_pulses"}, 32'(pulses), 32'(epulses));
  endtask

  initial begin
    logic [3:0] m1, m2, exp_cols, code;
    int         exp_p, n, r, c, dur;
    bit         long_press;

    km = '{'{4'h1, 4'h2, 4'h3, 4'hA},
           '{4'h4, 4'h5, 4'h6, 4'hB},
           '{4'h7, 4'h8, 4'h9, 4'hC},
           '{4'hE, 4'h0, 4'hF, 4'hD}};
    pressed = '0;
    reset   = 1'b1;
    cyc(2);
    check("rst_cols", 32'(cols), 32'h0000_000E);
    check("rst_s1", 32'(s1), 32'h0);
    check("rst_s2", 32'(s2), 32'h0);
    check("rst_new_key", 32'(new_key), 32'h0);

    // Column rotation: four cycles per column after reset release.
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      exp_cols = ~(4'b0001 << 2'((k / 4) % 4));
      check("rotate_cols", 32'(cols), 32'(exp_cols));
    end

    m1 = 4'h0; m2 = 4'h0; exp_p = 0;

    // Key '5'
    press(1, 1); cyc(100); release_all(); cyc(60);
    m2 = m1; m1 = km[1][1]; exp_p++;
    check_hist("key5", m1, m2, exp_p);

    // Key 'A'
    press(0, 3); cyc(100); release_all(); cyc(60);
    m2 = m1; m1 = km[0][3]; exp_p++;
    check_hist("keyA", m1, m2, exp_p);

    // Short '7' press is rejected
    press(2, 0); cyc(8); release_all(); cyc(40);
    check_hist("short7", m1, m2, exp_p);

    // Held '7' with chattering release
    press(2, 0); cyc(50);
    release_all(); cyc(3); press(2, 0); cyc(3);
    release_all(); cyc(3); press(2, 0); cyc(3);
    release_all(); cyc(60);
    m2 = m1; m1 = km[2][0]; exp_p++;
    check_hist("chatter7", m1, m2, exp_p);

    // '1' held, '9' joins; '9' waits for full release of '1'
    press(0, 0); cyc(50);
    press(2, 2); cyc(20);
    m2 = m1; m1 = km[0][0]; exp_p++;
    check_hist("hold1", m1, m2, exp_p);
    pressed[0][0] = 1'b0; cyc(10);
    check_hist("rel1_early", m1, m2, exp_p);
    cyc(60);
    m2 = m1; m1 = km[2][2]; exp_p++;
    check_hist("key9_after", m1, m2, exp_p);
    release_all(); cyc(60);
    check_hist("rel9", m1, m2, exp_p);

    // Reset during debounce of '3'
    n = 0;
    while (cols === 4'b1011 && n < 64) begin @(negedge clk); n++; end
    while (cols !== 4'b1011 && n < 64) begin @(negedge clk); n++; end
    check("s6_col2_seen", 32'(cols), 32'h0000_000B);
    press(0, 2); cyc(9);
    reset = 1'b1; release_all(); cyc(2);
    check("s6_rst_cols", 32'(cols), 32'h0000_000E);
    check_hist("s6_rst", 4'h0, 4'h0, exp_p);
    reset = 1'b0; cyc(30);
    check("s6_no_pulse", 32'(pulses), 32'(exp_p));
    m1 = 4'h0; m2 = 4'h0;
    press(0, 2); cyc(100); release_all(); cyc(60);
    m2 = m1; m1 = km[0][2]; exp_p++;
    check_hist("key3", m1, m2, exp_p);

    // Randomized presses: long ones register, short ones never do.
    for (int i = 0; i < 12; i++) begin
      r          = $urandom_range(0, 3);
      c          = $urandom_range(0, 3);
      long_press = 1'($urandom_range(0, 1));
      dur        = long_press ? $urandom_range(50, 90) : $urandom_range(1, 8);
      press(r, c); cyc(dur); release_all(); cyc(50);
      if (long_press) begin
        code = km[r][c];
        m2 = m1; m1 = code; exp_p++;
      end
      check_hist("rand", m1, m2, exp_p);
    end

    check("pulse_width", 32'(dbl), 32'h0);
    check("final_new_key", 32'(new_key), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Scans a 4x4 matrix keypad, synchronizes and debounces the row inputs, and registers one hex digit per physical key press. Keeps a two-deep history: s1 is the newest key and s2 the previous one. Sits directly upstream of dual_seg_driver and drives its s1/s2 inputs. One clock, clk (~12 MHz on board).

Parameters:
SCAN_DIV, 1200, clk cycles each column is driven during scanning (100 us at 12 MHz); must be >= 3.
DEBOUNCE_CYCLES, 240000, clk cycles a level must stay stable to be accepted (20 ms at 12 MHz).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
rows  input  4  keypad rows, asynchronous, pulled up; a row reads 0 when a key in the driven column is pressed
cols  output  4  keypad columns, active-low, exactly one bit low at all times
s1  output  4  newest registered key code
s2  output  4  previous registered key code
new_key  output  1  one-cycle pulse on the cycle s1/s2 update

Behaviour:
- Reset (synchronous, active-high), sampled on the clk edge, including mid-operation:
  - state <= SCAN, col_idx <= 0, all counters <= 0.
  - Outputs: cols = 4'b1110, s1 = 0, s2 = 0, new_key = 0.
  - Synchronizer flops <= 4'b1111.
- rows pass through a 2-flop synchronizer (rows_s); 2-cycle latency. All decisions use rows_s.
- cols = ~(4'b0001 << col_idx), registered.
- SCAN:
  - Dwell SCAN_DIV cycles per column.
  - On the last dwell cycle, if rows_s != 4'b1111: capture col_idx and the lowest-index low row, then go to DEBOUNCE. The column is frozen.
  - Otherwise col_idx <= col_idx+1, wrapping 3 -> 0.
- DEBOUNCE:
  - Count cycles while the captured row stays low.
  - If the captured row goes high on any cycle: go to SCAN, col_idx+1, no registration.
  - When the count reaches DEBOUNCE_CYCLES: s2 <= s1, s1 <= KEYMAP[row][col], new_key = 1 for that cycle only, go to HELD.
- HELD:
  - Column stays frozen; all other keys are ignored.
  - When the captured row reads high: go to RELEASE, counter <= 0.
- RELEASE:
  - Count cycles while the captured row stays high.
  - If the row goes low before DEBOUNCE_CYCLES: return to HELD, no new registration.
  - When the count reaches DEBOUNCE_CYCLES: go to SCAN at col_idx+1.
- Register timing: s1, s2 and new_key all change on the same edge. Counters saturate and never wrap.
- Simultaneous keys:
  - Same column: the lowest row index wins.
  - Different columns: the first column reached by the scan wins.
  - A second key pressed while one is held is never registered, including after the first is released, until a full release debounce completes and a fresh scan sample sees it.
- KEYMAP, indexed [row][col]:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E 0 F D

Decomposition:
- keypad_pkg:
  - state enum {SCAN, DEBOUNCE, HELD, RELEASE}.
  - KEYMAP constant array (4x4 of logic [3:0]).
  - Default SCAN_DIV and DEBOUNCE_CYCLES localparams.
- Sub-module sync2: 2-flop synchronizer, WIDTH parameter, reset value all-ones, same clk/reset. Used for rows.
- FSM, column counter and debounce counter stay in keypad_scanner.

Test Plan:
Bench setup: SCAN_DIV=4, DEBOUNCE_CYCLES=16. The keypad model drives rows[r]=0 iff key (r,c) is pressed and cols[c]==0.
1. Assert reset for 2 cycles -> cols=4'b1110, s1=0, s2=0, new_key=0. Released: cols rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110, every 4 cycles.
2. Press '5' (r1,c1) for 100 cycles, then release -> exactly one new_key pulse; s1=4'h5, s2=4'h0.
3. Then press 'A' (r0,c3) for 100 cycles, then release -> one pulse; s1=4'hA, s2=4'h5.
4. Bounce cases:
   - Press '7' for 8 cycles, then release -> no new_key; s1/s2 unchanged.
   - Hold '7' for 50 cycles, then chatter on release (toggle every 3 cycles for 12 cycles) -> exactly one pulse; s1=4'h7.
5. Hold '1'; after registration also press '9'; release '1' while '9' stays held, then release '9' -> one pulse (s1=4'h1) from '1'. '9' is registered only after '1' release debounce completes and '9' is still held when its column is scanned.
6. Press '3'; assert reset 6 cycles into DEBOUNCE -> s1=s2=0, cols=4'b1110, no pulse. Release, then press '3' again -> normal registration, s1=4'h3.
